// File: rtl/tmr_fault_logger_if.sv
// Record drain interface of the TMR fault logger: valid/ready with the head record fields.
// The logger drives the record (master); the debug/telemetry consumer drives ready (slave).
interface tmr_fault_logger_if #(
    parameter int WIDTH = 128
);
    logic             rec_valid;
    logic             rec_ready;
    logic [2:0]       rec_mask;
    logic [WIDTH-1:0] rec_stamp;

    modport master (
        output rec_valid,
        output rec_mask,
        output rec_stamp,
        input  rec_ready
    );

    modport slave (
        input  rec_valid,
        input  rec_mask,
        input  rec_stamp,
        output rec_ready
    );
endinterface

// File: rtl/tmr_fault_logger.sv
// Monitors the TMR voter fault flags: saturating per-replica event counters, sticky
// persistent-fault flags, and a timestamped FWFT FIFO of fault-pattern changes.
module tmr_fault_logger #(
    parameter int WIDTH   = 128,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 16,
    parameter int PERSIST = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     q_voted_i,
    input  logic [2:0]           fault_i,
    input  logic                 clear_i,
    tmr_fault_logger_if.master   rec_if,
    output logic [CNT_W-1:0]     fault_cnt0_o,
    output logic [CNT_W-1:0]     fault_cnt1_o,
    output logic [CNT_W-1:0]     fault_cnt2_o,
    output logic [2:0]           persistent_o,
    output logic                 overflow_o
);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RUN_W = $clog2(PERSIST + 1);
    localparam logic [AW:0]      DEPTH_C   = (AW+1)'(DEPTH);
    localparam logic [RUN_W-1:0] PERSIST_C = RUN_W'(PERSIST);

    logic [2:0]       fault_q;
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];
    logic [RUN_W-1:0] run_q [3];
    logic [RUN_W-1:0] run_d [3];
    logic [2:0]       persistent_q, persistent_d;
    logic             overflow_q, overflow_d;

    logic [2:0]       mem_mask_q  [DEPTH];
    logic [WIDTH-1:0] mem_stamp_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d, count_after_pop;
    logic [2:0]       head_mask_q, head_mask_d;
    logic [WIDTH-1:0] head_stamp_q, head_stamp_d;

    logic event_w, pop_w, full_w, push_w, drop_w;

    always_comb begin
        event_w = (fault_i != 3'b000) && (fault_i != fault_q);
        pop_w   = (count_q != '0) && rec_if.rec_ready;
        full_w  = (count_q == DEPTH_C);
        push_w  = event_w && (!full_w || pop_w);
        drop_w  = event_w && full_w && !pop_w;

        rd_ptr_d        = pop_w  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d        = push_w ? wr_ptr_q + AW'(1) : wr_ptr_q;
        count_after_pop = count_q - (AW+1)'(pop_w);
        count_d         = count_after_pop + (AW+1)'(push_w);

        // Head is registered so the outputs hold the last record once the FIFO drains.
        head_mask_d  = head_mask_q;
        head_stamp_d = head_stamp_q;
        if (count_d != '0) begin
            if (count_after_pop == '0) begin
                head_mask_d  = fault_i;
                head_stamp_d = q_voted_i;
            end else begin
                head_mask_d  = mem_mask_q[rd_ptr_d];
                head_stamp_d = mem_stamp_q[rd_ptr_d];
            end
        end
    end

    always_comb begin
        persistent_d = persistent_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = cnt_q[i];
            run_d[i] = '0;
            if (fault_i[i] && !fault_q[i] && (cnt_q[i] != '1))
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            if (fault_i[i])
                run_d[i] = (run_q[i] == PERSIST_C) ? run_q[i] : run_q[i] + RUN_W'(1);
            if (run_d[i] == PERSIST_C)
                persistent_d[i] = 1'b1;
        end
        overflow_d = overflow_q | drop_w;
        if (clear_i) begin
            for (int i = 0; i < 3; i++) begin
                cnt_d[i] = '0;
                run_d[i] = '0;
            end
            persistent_d = '0;
            overflow_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q      <= '0;
            persistent_q <= '0;
            overflow_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            head_mask_q  <= '0;
            head_stamp_q <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
                run_q[i] <= '0;
            end
        end else begin
            fault_q      <= fault_i;
            persistent_q <= persistent_d;
            overflow_q   <= overflow_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            head_mask_q  <= head_mask_d;
            head_stamp_q <= head_stamp_d;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
                run_q[i] <= run_d[i];
            end
        end
    end

    // Storage is only ever read behind valid pointers, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push_w) begin
            mem_mask_q[wr_ptr_q]  <= fault_i;
            mem_stamp_q[wr_ptr_q] <= q_voted_i;
        end
    end

    assign rec_if.rec_valid = (count_q != '0);
    assign rec_if.rec_mask  = head_mask_q;
    assign rec_if.rec_stamp = head_stamp_q;
    assign fault_cnt0_o     = cnt_q[0];
    assign fault_cnt1_o     = cnt_q[1];
    assign fault_cnt2_o     = cnt_q[2];
    assign persistent_o     = persistent_q;
    assign overflow_o       = overflow_q;
endmodule

// File: tb/tb_tmr_fault_logger.sv
// Scoreboard bench for tmr_fault_logger: a behavioural model predicts records, counters,
// persistence and overflow; every cycle the DUT outputs are compared against it.
module tb_tmr_fault_logger;
    localparam int WIDTH   = 128;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = 4;
    localparam int PERSIST = 3;

    typedef struct packed {
        logic [2:0]       mask;
        logic [WIDTH-1:0] stamp;
    } rec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] q_voted = '0;
    logic [2:0]       fault = '0;
    logic             clear = 1'b0;
    logic [CNT_W-1:0] fault_cnt0, fault_cnt1, fault_cnt2;
    logic [2:0]       persistent;
    logic             overflow;

    always #5 clk = ~clk;

    tmr_fault_logger_if #(.WIDTH(WIDTH)) rec_if ();

    tmr_fault_logger #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W), .PERSIST(PERSIST)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .q_voted_i    (q_voted),
        .fault_i      (fault),
        .clear_i      (clear),
        .rec_if       (rec_if.master),
        .fault_cnt0_o (fault_cnt0),
        .fault_cnt1_o (fault_cnt1),
        .fault_cnt2_o (fault_cnt2),
        .persistent_o (persistent),
        .overflow_o   (overflow)
    );

    rec_t       sb_q[$];
    rec_t       m_last;
    logic [2:0] m_fq;
    logic [2:0] m_pers;
    logic       m_ovf;
    int         m_cnt[3];
    int         m_run[3];
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_last = '0;
        m_fq   = '0;
        m_pers = '0;
        m_ovf  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0;
            m_run[i] = 0;
        end
    endtask

    task automatic check_outputs();
        chk("rec_valid", WIDTH'(rec_if.rec_valid), WIDTH'(sb_q.size() != 0));
        if (sb_q.size() != 0) begin
            chk("rec_mask", WIDTH'(rec_if.rec_mask), WIDTH'(sb_q[0].mask));
            chk("rec_stamp", rec_if.rec_stamp, sb_q[0].stamp);
        end else begin
            chk("hold_mask", WIDTH'(rec_if.rec_mask), WIDTH'(m_last.mask));
            chk("hold_stamp", rec_if.rec_stamp, m_last.stamp);
        end
        chk("fault_cnt0", WIDTH'(fault_cnt0), WIDTH'(m_cnt[0]));
        chk("fault_cnt1", WIDTH'(fault_cnt1), WIDTH'(m_cnt[1]));
        chk("fault_cnt2", WIDTH'(fault_cnt2), WIDTH'(m_cnt[2]));
        chk("persistent", WIDTH'(persistent), WIDTH'(m_pers));
        chk("overflow", WIDTH'(overflow), WIDTH'(m_ovf));
    endtask

    // Drive one cycle's inputs, compare the current outputs, advance the model, then clock.
    task automatic step(input logic [2:0] f, input logic [WIDTH-1:0] ts, input logic rdy, input logic clr);
        logic pop, ev, drop;
        fault           = f;
        q_voted         = ts;
        rec_if.rec_ready = rdy;
        clear           = clr;
        check_outputs();
        pop  = (sb_q.size() != 0) && rdy;
        ev   = (f != 3'b000) && (f != m_fq);
        drop = 1'b0;
        if (pop) m_last = sb_q.pop_front();
        if (ev) begin
            if (sb_q.size() < DEPTH) sb_q.push_back(rec_t'{mask: f, stamp: ts});
            else drop = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            if (clr) begin
                m_cnt[i] = 0;
                m_run[i] = 0;
            end else begin
                if (f[i] && !m_fq[i] && m_cnt[i] < (1 << CNT_W) - 1) m_cnt[i]++;
                m_run[i] = f[i] ? ((m_run[i] < PERSIST) ? m_run[i] + 1 : m_run[i]) : 0;
                if (m_run[i] == PERSIST) m_pers[i] = 1'b1;
            end
        end
        if (clr) begin
            m_pers = '0;
            m_ovf  = 1'b0;
        end else begin
            m_ovf = m_ovf | drop;
        end
        m_fq = f;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] rnd_ts();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        rec_if.rec_ready = 1'b0;
        model_reset();
        #22 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_valid", WIDTH'(rec_if.rec_valid), '0);
        chk("reset_stamp", rec_if.rec_stamp, '0);

        // single event
        step(3'b000, rnd_ts(), 1'b0, 1'b0);
        step(3'b010, WIDTH'(8'h2A), 1'b0, 1'b0);
        chk("single_mask", WIDTH'(rec_if.rec_mask), WIDTH'(3'b010));
        chk("single_stamp", rec_if.rec_stamp, WIDTH'(8'h2A));
        chk("single_cnt1", WIDTH'(fault_cnt1), WIDTH'(1));
        step(3'b000, rnd_ts(), 1'b1, 1'b0);
        chk("single_popped", WIDTH'(rec_if.rec_valid), '0);

        // mask change and hold
        step(3'b001, rnd_ts(), 1'b0, 1'b0);
        step(3'b001, rnd_ts(), 1'b0, 1'b0);
        step(3'b011, rnd_ts(), 1'b0, 1'b0);
        step(3'b011, rnd_ts(), 1'b0, 1'b0);
        step(3'b000, rnd_ts(), 1'b0, 1'b0);
        chk("hold_persistent", WIDTH'(persistent), WIDTH'(3'b001));
        chk("hold_head", WIDTH'(rec_if.rec_mask), WIDTH'(3'b001));
        for (int i = 0; i < 3; i++) step(3'b000, rnd_ts(), 1'b1, 1'b0);

        // overflow, then push+pop while full
        step(3'b001, rnd_ts(), 1'b0, 1'b0);
        step(3'b010, rnd_ts(), 1'b0, 1'b0);
        step(3'b100, rnd_ts(), 1'b0, 1'b0);
        step(3'b011, rnd_ts(), 1'b0, 1'b0);
        step(3'b101, rnd_ts(), 1'b0, 1'b0);
        chk("ovf_set", WIDTH'(overflow), WIDTH'(1));
        chk("ovf_head", WIDTH'(rec_if.rec_mask), WIDTH'(3'b001));
        step(3'b110, rnd_ts(), 1'b1, 1'b0);
        chk("ovf_keep", WIDTH'(overflow), WIDTH'(1));
        for (int i = 0; i < 5; i++) step(3'b110, rnd_ts(), 1'b1, 1'b0);
        step(3'b000, rnd_ts(), 1'b1, 1'b0);

        // counter saturation on replica 3, including 111 masks
        for (int i = 0; i < 20; i++) begin
            step((i % 5 == 0) ? 3'b111 : 3'b100, rnd_ts(), 1'b1, 1'b0);
            step(3'b000, rnd_ts(), 1'b1, 1'b0);
        end
        chk("sat_cnt2", WIDTH'(fault_cnt2), WIDTH'(15));

        // clear in the same cycle as an event, FIFO nonempty
        step(3'b010, rnd_ts(), 1'b0, 1'b0);
        step(3'b011, rnd_ts(), 1'b0, 1'b1);
        chk("clr_cnt0", WIDTH'(fault_cnt0), '0);
        chk("clr_pers", WIDTH'(persistent), '0);
        chk("clr_ovf", WIDTH'(overflow), '0);
        step(3'b011, rnd_ts(), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(3'b011, rnd_ts(), 1'b1, 1'b0);
        step(3'b000, rnd_ts(), 1'b1, 1'b0);

        // async reset mid-burst with 3 records queued
        step(3'b001, rnd_ts(), 1'b0, 1'b0);
        step(3'b011, rnd_ts(), 1'b0, 1'b0);
        step(3'b111, rnd_ts(), 1'b0, 1'b0);
        check_outputs();
        fault = 3'b000;
        #3 rst_n = 1'b0;
        #1;
        chk("arst_valid", WIDTH'(rec_if.rec_valid), '0);
        chk("arst_mask", WIDTH'(rec_if.rec_mask), '0);
        chk("arst_stamp", rec_if.rec_stamp, '0);
        chk("arst_cnt", WIDTH'({fault_cnt0, fault_cnt1, fault_cnt2}), '0);
        chk("arst_pers", WIDTH'(persistent), '0);
        chk("arst_ovf", WIDTH'(overflow), '0);
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(3'b100, rnd_ts(), 1'b0, 1'b0);
        step(3'b000, rnd_ts(), 1'b1, 1'b0);
        step(3'b000, rnd_ts(), 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
